// File: rtl/quad_pkg.sv
// Shared encodings and helpers for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] Q_S00 = 2'b00;
    localparam logic [1:0] Q_S01 = 2'b01;
    localparam logic [1:0] Q_S11 = 2'b11;
    localparam logic [1:0] Q_S10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DW = 1'b0;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } step_t;

    // Forward (count-up) successor in the Gray sequence 00->01->11->10->00.
    function automatic logic [1:0] q_next_fwd(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            Q_S00:   n = Q_S01;
            Q_S01:   n = Q_S11;
            Q_S11:   n = Q_S10;
            default: n = Q_S00;
        endcase
        return n;
    endfunction

    function automatic step_t q_classify(input logic [1:0] prev, input logic [1:0] cur);
        step_t st;
        if (cur == prev)
            st = STEP_NONE;
        else if (cur == q_next_fwd(prev))
            st = STEP_FWD;
        else if (prev == q_next_fwd(cur))
            st = STEP_REV;
        else
            st = STEP_ILL;
        return st;
    endfunction

    function automatic int unsigned q_latency(input int unsigned sync_stages,
                                              input int unsigned filt_len);
        return sync_stages + filt_len + 1;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: P_SYNC_STAGES synchroniser followed by a persistence
// glitch filter that accepts a new level after P_FILT_LEN stable cycles.
module quad_input_filter #(
    parameter int P_SYNC_STAGES = 2,
    parameter int P_FILT_LEN    = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = (P_FILT_LEN > 1) ? $clog2(P_FILT_LEN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(P_FILT_LEN - 1);

    logic [P_SYNC_STAGES-1:0] r_sync;
    logic                     r_filt;
    logic [CW-1:0]            r_cnt;
    logic                     w_s;

    assign w_s    = r_sync[P_SYNC_STAGES-1];
    assign o_filt = r_filt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[P_SYNC_STAGES-2:0], i_raw};
            // Any return to the accepted level restarts the persistence count.
            if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder producing enable/up_dw for the up/down counter.
// Define QUAD_X1_DECODE_EN for x1 decoding (one pulse per full cycle); default is x4.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int P_SYNC_STAGES = 2,
    parameter int P_FILT_LEN    = 4,
    parameter int P_ERR_BIT     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_a,
    input  logic                 in_b,
    output logic                 enable,
    output logic                 up_dw,
    output logic                 error,
    output logic [P_ERR_BIT-1:0] err_count
);

    logic       w_fa;
    logic       w_fb;
    logic [1:0] w_cur;
    logic [1:0] r_prev;
    step_t      w_step;

    quad_input_filter #(
        .P_SYNC_STAGES (P_SYNC_STAGES),
        .P_FILT_LEN    (P_FILT_LEN)
    ) u_filt_a (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_raw  (in_a),
        .o_filt (w_fa)
    );

    quad_input_filter #(
        .P_SYNC_STAGES (P_SYNC_STAGES),
        .P_FILT_LEN    (P_FILT_LEN)
    ) u_filt_b (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_raw  (in_b),
        .o_filt (w_fb)
    );

    assign w_cur  = {w_fa, w_fb};
    assign w_step = q_classify(r_prev, w_cur);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev    <= Q_S00;
            enable    <= 1'b0;
            error     <= 1'b0;
            up_dw     <= DIR_UP;
            err_count <= '0;
        end else begin
            r_prev <= w_cur;
            enable <= 1'b0;
            error  <= 1'b0;
            case (w_step)
                STEP_FWD: begin
`ifdef QUAD_X1_DECODE_EN
                    if (r_prev == Q_S10 && w_cur == Q_S00) begin
                        enable <= 1'b1;
                        up_dw  <= DIR_UP;
                    end
`else
                    enable <= 1'b1;
                    up_dw  <= DIR_UP;
`endif
                end
                STEP_REV: begin
`ifdef QUAD_X1_DECODE_EN
                    if (r_prev == Q_S00 && w_cur == Q_S10) begin
                        enable <= 1'b1;
                        up_dw  <= DIR_DW;
                    end
`else
                    enable <= 1'b1;
                    up_dw  <= DIR_DW;
`endif
                end
                STEP_ILL: error <= 1'b1;
                default: ;
            endcase
            // clear takes priority; the counter sticks at all-ones.
            if (clear)
                err_count <= '0;
            else if (w_step == STEP_ILL && err_count != '1)
                err_count <= err_count + P_ERR_BIT'(1);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stepping, direction, glitches, errors, reset.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int LAT = q_latency(2, 4);

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       clear2 = 1'b0;
    logic       in_a;
    logic       in_b;
    logic       enable, up_dw, error;
    logic [7:0] err_count;
    logic       enable2, up_dw2, error2;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    quad_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_a      (in_a),
        .in_b      (in_b),
        .enable    (enable),
        .up_dw     (up_dw),
        .error     (error),
        .err_count (err_count)
    );

    quad_decoder #(.P_ERR_BIT(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear2),
        .in_a      (in_a),
        .in_b      (in_b),
        .enable    (enable2),
        .up_dw     (up_dw2),
        .error     (error2),
        .err_count (err_count2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   en_cnt = 0, err_cnt = 0, en2_cnt = 0, err2_cnt = 0, dir2_bad = 0;
    logic up_q[$];
    int   en_cyc_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (enable) begin
                en_cnt++;
                up_q.push_back(up_dw);
                en_cyc_q.push_back(cyc);
            end
            if (error)  err_cnt++;
            if (enable2) begin
                en2_cnt++;
                if (up_dw2 != up_dw) dir2_bad++;
            end
            if (error2) err2_cnt++;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic a, input logic b, input int hold);
        in_a = a;
        in_b = b;
        repeat (hold) @(negedge clk);
    endtask

    function automatic int up_at(input int idx);
        if (idx < up_q.size()) return int'(up_q[idx]);
        return -1;
    endfunction

    function automatic int lat_at(input int idx, input int t0);
        if (idx < en_cyc_q.size()) return en_cyc_q[idx] - t0;
        return -1;
    endfunction

    function automatic int ups_in(input int from, input int n);
        int s = 0;
        for (int i = from; i < from + n; i++)
            if (i < up_q.size() && up_q[i]) s++;
        return s;
    endfunction

    int e0, r0, q0, t0;

    initial begin
        reset = 1'b1; clear = 1'b0; in_a = 1'b0; in_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", int'(enable), 0);
        check("rst_error", int'(error), 0);
        check("rst_up_dw", int'(up_dw), 1);
        check("rst_err_count", int'(err_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8 forward steps
        e0 = en_cnt; r0 = err_cnt; q0 = up_q.size(); t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 10); step(1, 1, 10); step(1, 0, 10); step(0, 0, 10);
        end
        repeat (10) @(negedge clk);
`ifdef QUAD_X1_DECODE_EN
        check("fwd_pulses_x1", en_cnt - e0, 2);
`else
        check("fwd_pulses", en_cnt - e0, 8);
        check("fwd_latency", lat_at(q0, t0), LAT);
        check("fwd_all_up", ups_in(q0, 8), 8);
`endif
        check("fwd_errors", err_cnt - r0, 0);
        check("fwd_err_count", int'(err_count), 0);

        // 4 forward then 4 reverse
        e0 = en_cnt; q0 = up_q.size();
        step(0, 1, 10); step(1, 1, 10); step(1, 0, 10); step(0, 0, 10);
        step(1, 0, 10); step(1, 1, 10); step(0, 1, 10); step(0, 0, 10);
        repeat (10) @(negedge clk);
        check("rev_pulses", en_cnt - e0, 8);
        check("rev_4th_up", up_at(q0 + 3), 1);
        check("rev_5th_down", up_at(q0 + 4), 0);
        check("rev_last4_ups", ups_in(q0 + 4, 4), 0);

        // glitch shorter than the filter, then one just long enough
        e0 = en_cnt; r0 = err_cnt; q0 = up_q.size();
        step(1, 0, 3); step(0, 0, 15);
        check("glitch3_pulses", en_cnt - e0, 0);
        check("glitch3_errors", err_cnt - r0, 0);
        step(1, 0, 4); step(0, 0, 15);
        check("pulse4_pulses", en_cnt - e0, 2);
        check("pulse4_first_down", up_at(q0), 0);
        check("pulse4_second_up", up_at(q0 + 1), 1);
        check("pulse4_errors", err_cnt - r0, 0);

        // down step, then double-bit change 10->01
        e0 = en_cnt; r0 = err_cnt;
        step(1, 0, 10);
        step(0, 1, 10);
        check("ill_enables", en_cnt - e0, 1);
        check("ill_errors", err_cnt - r0, 1);
        check("ill_err_count", int'(err_count), 1);
        check("ill_up_dw_held", int'(up_dw), 0);

        // double-bit change 01->10 with clear held across the increment
        in_a = 1'b1; in_b = 1'b0; clear = 1'b1;
        repeat (10) @(negedge clk);
        clear = 1'b0;
        repeat (5) @(negedge clk);
        check("clr_err_count", int'(err_count), 0);
        check("clr_errors", err_cnt - r0, 2);
        check("clr_up_dw", int'(up_dw), 0);
        check("clr_err2_count", int'(err_count2), 2);

        // three more illegal transitions: narrow counter saturates
        e0 = en_cnt;
        step(0, 1, 10); step(1, 0, 10); step(0, 1, 10);
        repeat (5) @(negedge clk);
        check("sat_err2_count", int'(err_count2), 3);
        check("sat_err2_pulses", err2_cnt, 5);
        check("sat_err_count", int'(err_count), 3);
        check("sat_enables", en_cnt - e0, 0);

        // reset during an in-flight filter count
        in_b = 1'b0;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_enable", int'(enable), 0);
        check("async_error", int'(error), 0);
        check("async_up_dw", int'(up_dw), 1);
        check("async_err_count", int'(err_count), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        e0 = en_cnt; r0 = err_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_enables", en_cnt - e0, 0);
        check("post_rst_errors", err_cnt - r0, 0);

        // fresh stable change after reset
        q0 = up_q.size(); t0 = cyc;
        step(0, 1, 15);
        check("fresh_pulses", en_cnt - e0, 1);
        check("fresh_latency", lat_at(q0, t0), LAT);
        check("fresh_up", up_at(q0), 1);

        check("dut2_enables_match", en2_cnt, en_cnt);
        check("dut2_dir_match", dir2_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
